// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall control for a five-stage pipeline: operand forwarding, RAW stall
// detection, branch flush, memory-wait freeze with timeout, and a stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fwd_en,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_two_src,
  input  logic [3:0]  exe_src1,
  input  logic [3:0]  exe_src2,
  input  logic [3:0]  exe_dest,
  input  logic        exe_wb_en,
  input  logic        exe_mem_r_en,
  input  logic [3:0]  mem_dest,
  input  logic        mem_wb_en,
  input  logic [3:0]  wb_dest,
  input  logic        wb_wb_en,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        clr_stats,
  output logic [1:0]  sel_src1,
  output logic [1:0]  sel_src2,
  output logic        hazard_stall,
  output logic        flush,
  output logic        freeze,
  output logic        wait_state,
  output logic        timeout,
  output logic [15:0] stall_cycles
);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [7:0] LIMIT   = 8'(WAIT_LIMIT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       raw_hazard;
  logic       id_hit_exe, id_hit_mem;

  function automatic logic [1:0] fwd_sel(input logic [3:0] src, input logic en,
                                         input logic m_en, input logic [3:0] m_dest,
                                         input logic w_en, input logic [3:0] w_dest);
    if (!en)                         return SEL_RF;
    else if (m_en && m_dest == src)  return SEL_MEM;
    else if (w_en && w_dest == src)  return SEL_WB;
    else                             return SEL_RF;
  endfunction

  function automatic logic id_match(input logic [3:0] d, input logic en);
    return en && ((d == id_src1) || (id_two_src && d == id_src2));
  endfunction

  assign sel_src1 = fwd_sel(exe_src1, fwd_en, mem_wb_en, mem_dest, wb_wb_en, wb_dest);
  assign sel_src2 = fwd_sel(exe_src2, fwd_en, mem_wb_en, mem_dest, wb_wb_en, wb_dest);

  assign id_hit_exe = id_match(exe_dest, exe_wb_en);
  assign id_hit_mem = id_match(mem_dest, mem_wb_en);

  // With forwarding only a load result is too late; without it any in-flight writer stalls.
  assign raw_hazard = fwd_en ? (id_hit_exe && exe_mem_r_en) : (id_hit_exe || id_hit_mem);

  assign freeze       = mem_req && !mem_ready;
  assign flush        = branch_taken && !freeze;
  assign hazard_stall = raw_hazard && !freeze && !branch_taken;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (freeze)                 state_nxt = S_WAIT;
      S_WAIT:  if (mem_ready || !mem_req)  state_nxt = S_RUN;
      default:                             state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    wait_state = (state == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst || state == S_RUN)          wait_cnt <= '0;
    else if (freeze && wait_cnt != '1)  wait_cnt <= wait_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_stats)        timeout <= 1'b0;
    else if (wait_cnt >= LIMIT)  timeout <= 1'b1;
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clr_stats)
      stall_cycles <= '0;
    else if ((hazard_stall || freeze) && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end

endmodule
